// File: rtl/cpu_trace_pkg.sv
// Shared types and record layout for the commit-trace buffer.
// TRACE_TIMESTAMP_EN prepends a 32-bit cycle stamp to every record.
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    TRC_IDLE    = 2'd0,
    TRC_ARMED   = 2'd1,
    TRC_CAPTURE = 2'd2,
    TRC_DONE    = 2'd3
  } trc_state_e;

  localparam int PC_W       = 32;
  localparam int INST_W     = 32;
  localparam int DATA_W     = 32;
  localparam int RADDR_W    = 5;
  localparam int BASE_REC_W = 1 + RADDR_W + DATA_W + INST_W + PC_W;

`ifdef TRACE_TIMESTAMP_EN
  localparam int TS_W = 32;
`else
  localparam int TS_W = 0;
`endif

  localparam int REC_W = BASE_REC_W + TS_W;

  // Layout, MSB first: {rf_we, rf_waddr, rf_wdata, inst, pc_offset}.
  function automatic logic [BASE_REC_W-1:0] pack_rec(
    input logic               we,
    input logic [RADDR_W-1:0] waddr,
    input logic [DATA_W-1:0]  wdata,
    input logic [INST_W-1:0]  inst,
    input logic [PC_W-1:0]    pc_off
  );
    return {we, waddr, wdata, inst, pc_off};
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular RAM FIFO with show-ahead read and optional overwrite-oldest on full.
// Handshake: a pop happens when i_pop is high while o_valid is high.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  input  logic             i_wrap,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_valid,
  output logic             o_full,
  output logic             o_overwrite
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_overwrite;

  assign w_full      = (r_count == FULL_CNT);
  assign w_pop       = i_pop && (r_count != '0);
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign w_push      = i_push && (!w_full || w_pop || i_wrap);
  assign w_overwrite = w_push && w_full && !w_pop;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop || w_overwrite) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop && !w_overwrite) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign o_valid     = (r_count != '0);
  assign o_rdata     = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_full      = w_full;
  assign o_overwrite = w_overwrite;

endmodule

// File: rtl/cpu_trace_buffer.sv
// Commit-trace capture: arm/trigger/stop FSM, filter, counters and record packing.
// Define TRACE_TIMESTAMP_EN to prepend a free-running cycle stamp to each record.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int          DEPTH       = 256,
  parameter int          MAX_RECORDS = 2048,
  parameter logic [31:0] PC_BASE     = 32'h00400000,
  localparam int         CW          = $clog2(MAX_RECORDS + 1)
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              trc_valid,
  input  logic [31:0]       trc_pc,
  input  logic [31:0]       trc_inst,
  input  logic              trc_rf_we,
  input  logic [4:0]        trc_rf_waddr,
  input  logic [31:0]       trc_rf_wdata,
  input  logic              trc_halt,
  input  logic              arm,
  input  logic              clear,
  input  logic              trig_en,
  input  logic [31:0]       trig_pc,
  input  logic              wb_only,
  input  logic              wrap_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REC_W-1:0]  out_data,
  output logic [1:0]        state,
  output logic [CW-1:0]     cap_count,
  output logic [15:0]       dropped
);

  localparam logic [CW-1:0] CAP_MAX = CW'(MAX_RECORDS);

  trc_state_e r_state;
  trc_state_e w_state_nxt;

  logic [CW-1:0]    r_cap_count;
  logic [15:0]      r_dropped;
  logic [REC_W-1:0] w_rec;
  logic             w_flush;
  logic             w_trig_hit;
  logic             w_active;
  logic             w_push_req;
  logic             w_discard;
  logic             w_push;
  logic             w_pop;
  logic             w_cap_hit;
  logic             w_stop;
  logic             w_fifo_valid;
  logic             w_fifo_full;
  logic             w_overwrite;

  assign w_flush    = reset || clear;
  assign w_trig_hit = trc_valid && (!trig_en || (trc_pc == trig_pc));
  // The triggering commit is captured in the same cycle the FSM leaves ARMED.
  assign w_active   = (r_state == TRC_CAPTURE) || ((r_state == TRC_ARMED) && w_trig_hit);
  assign w_push_req = w_active && trc_valid && (!wb_only || trc_rf_we);
  assign w_pop      = w_fifo_valid && out_ready;
  assign w_discard  = w_push_req && w_fifo_full && !w_pop && !wrap_mode;
  assign w_push     = w_push_req && !w_discard;
  assign w_cap_hit  = w_push && ((r_cap_count + CW'(1)) == CAP_MAX);
  assign w_stop     = w_active && (trc_halt || w_discard || w_cap_hit);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state <= TRC_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      TRC_IDLE:    if (arm)        w_state_nxt = TRC_ARMED;
      TRC_ARMED:   if (w_trig_hit) w_state_nxt = w_stop ? TRC_DONE : TRC_CAPTURE;
      TRC_CAPTURE: if (w_stop)     w_state_nxt = TRC_DONE;
      TRC_DONE:                    w_state_nxt = TRC_DONE;
      default:                     w_state_nxt = TRC_IDLE;
    endcase
    if (clear) begin
      w_state_nxt = TRC_IDLE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_flush) begin
      r_cap_count <= '0;
      r_dropped   <= '0;
    end else begin
      if (w_push && (r_cap_count != CAP_MAX)) begin
        r_cap_count <= r_cap_count + CW'(1);
      end
      if (w_overwrite && (r_dropped != 16'hFFFF)) begin
        r_dropped <= r_dropped + 16'd1;
      end
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;

  always_ff @(posedge clk_in) begin
    if (w_flush) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
    end
  end

  assign w_rec = {r_ts, pack_rec(trc_rf_we, trc_rf_waddr, trc_rf_wdata, trc_inst, trc_pc - PC_BASE)};
`else
  assign w_rec = pack_rec(trc_rf_we, trc_rf_waddr, trc_rf_wdata, trc_inst, trc_pc - PC_BASE);
`endif

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (clk_in),
    .i_flush     (w_flush),
    .i_push      (w_push),
    .i_wdata     (w_rec),
    .i_pop       (out_ready),
    .i_wrap      (wrap_mode),
    .o_rdata     (out_data),
    .o_valid     (w_fifo_valid),
    .o_full      (w_fifo_full),
    .o_overwrite (w_overwrite)
  );

  assign out_valid = w_fifo_valid;
  assign state     = r_state;
  assign cap_count = r_cap_count;
  assign dropped   = r_dropped;

endmodule
